// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   op_e      - opcode encoding (4 bits; all other codes are illegal)
//   state_e   - control FSM states
//   STATUS_*  - bit positions inside the 3-bit {N, V, Z} status word
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_DIVU = 4'b1001,
    OP_REMU = 4'b1010
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int STATUS_N = 2;
  localparam int STATUS_V = 1;
  localparam int STATUS_Z = 0;

endpackage

// File: rtl/alu_seq_muldiv.sv
// muldiv_iter: iterative multiply / restoring-divide datapath, one step per
// clock for exactly WIDTH clocks after start.
//   clk, rst_n      - clock, async active-low reset
//   start           - load operands and begin WIDTH iterations
//   div_mode        - (only with ALU_SEQ_DIV_EN) 1 = divide, 0 = multiply
//   a, b            - operands, sampled on start
//   done            - the step taken at the coming edge is the last one
//   lo_next/hi_next - register values after the current step:
//                     multiply: low/high product halves
//                     divide:   quotient/remainder
// Macro ALU_SEQ_DIV_EN: when undefined, no divider logic is built.
module muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef ALU_SEQ_DIV_EN
  input  logic             div_mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   mul_sum;

`ifdef ALU_SEQ_DIV_EN
  logic             mode;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Remainder shifted left with the next dividend bit pulled in from lo;
  // a non-negative trial difference means the quotient bit is 1.
  // With a zero divisor every trial succeeds, giving an all-ones quotient
  // and a remainder equal to the dividend.
  assign shifted = {hi, lo[WIDTH-1]};
  assign trial   = shifted - {1'b0, opnd};
`endif

  // Shift-add multiply: {hi, lo} starts as {0, a}; add b into hi when the
  // current multiplier bit lo[0] is set, then shift the pair right by one.
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);

  always_comb begin
    hi_next = mul_sum[WIDTH:1];
    lo_next = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    if (mode) begin
      hi_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], ~trial[WIDTH]};
    end
`endif
  end

  assign done = (count == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
`ifdef ALU_SEQ_DIV_EN
      mode  <= 1'b0;
`endif
    end else if (start) begin
      count <= CW'(WIDTH);
      hi    <= '0;
      lo    <= a;
      opnd  <= b;
`ifdef ALU_SEQ_DIV_EN
      mode  <= div_mode;
`endif
    end else if (count != '0) begin
      count <= count - CW'(1);
      hi    <= hi_next;
      lo    <= lo_next;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete one cycle after acceptance; MUL/DIVU/REMU spend
// WIDTH cycles in BUSY in the muldiv_iter datapath.
//   clk, rst_n          - clock, async active-low reset
//   in_valid / in_ready - request handshake; op, a, b sampled on acceptance
//   out_valid/out_ready - result handshake; result/status/err held until taken
//   status              - {N, V, Z}
//   err                 - illegal or disabled opcode
// Macro ALU_SEQ_DIV_EN: enables DIVU/REMU; otherwise they are illegal.
//
// state | meaning
// IDLE  | waiting for a request
// BUSY  | iterative multiply/divide running
// DONE  | result presented, waiting for out_ready
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       status,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state;
  logic [3:0]       op4;
  logic [3:0]       long_op;
  logic             op_hi_zero;
  logic             accept;
  logic             is_long;
  logic             start;
  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic             v_add;
  logic             v_sub;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic             alu_err;
  logic [2:0]       alu_status;
  logic             md_done;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] long_res;
  logic             long_v;
  logic [2:0]       long_status;

  // Opcode bits above the 4-bit encoding must be zero for a legal op.
  assign op4        = 4'(op);
  assign op_hi_zero = ((op >> 4) == '0);

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign start    = accept && is_long;

  // Overflow = carry into MSB xor carry out of MSB.
  assign sum_add = {1'b0, a} + {1'b0, b};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign v_add   = sum_add[WIDTH] ^ (a[WIDTH-1] ^ b[WIDTH-1] ^ sum_add[WIDTH-1]);
  assign v_sub   = sum_sub[WIDTH] ^ (a[WIDTH-1] ^ ~b[WIDTH-1] ^ sum_sub[WIDTH-1]);
  assign shamt   = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    is_long = 1'b0;
    if (!op_hi_zero) begin
      alu_err = 1'b1;
    end else begin
      case (op4)
        OP_AND: alu_res = a & b;
        OP_OR:  alu_res = a | b;
        OP_XOR: alu_res = a ^ b;
        OP_ADD: begin
          alu_res = sum_add[WIDTH-1:0];
          alu_v   = v_add;
        end
        OP_SUB: begin
          alu_res = sum_sub[WIDTH-1:0];
          alu_v   = v_sub;
        end
        OP_SLL: alu_res = a << shamt;
        OP_SRL: alu_res = a >> shamt;
        OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        OP_MUL: is_long = 1'b1;
`ifdef ALU_SEQ_DIV_EN
        OP_DIVU, OP_REMU: is_long = 1'b1;
`endif
        default: alu_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    alu_status           = '0;
    alu_status[STATUS_N] = alu_res[WIDTH-1];
    alu_status[STATUS_V] = alu_v;
    alu_status[STATUS_Z] = (alu_res == '0);
  end

  // Final long-op result is taken from the datapath's post-step values so
  // DONE is reached on the same edge as the last iteration.
  always_comb begin
    long_res = md_lo;
    long_v   = (long_op == OP_MUL) && (md_hi != '0);
`ifdef ALU_SEQ_DIV_EN
    if (long_op == OP_REMU) long_res = md_hi;
`endif
    long_status           = '0;
    long_status[STATUS_N] = long_res[WIDTH-1];
    long_status[STATUS_V] = long_v;
    long_status[STATUS_Z] = (long_res == '0);
  end

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef ALU_SEQ_DIV_EN
    .div_mode ((op4 == OP_DIVU) || (op4 == OP_REMU)),
`endif
    .a        (a),
    .b        (b),
    .done     (md_done),
    .lo_next  (md_lo),
    .hi_next  (md_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      status    <= '0;
      err       <= 1'b0;
      long_op   <= OP_MUL;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_long) begin
              state     <= ST_BUSY;
              out_valid <= 1'b0;
              long_op   <= op4;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              result    <= alu_res;
              status    <= alu_status;
              err       <= alu_err;
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result    <= long_res;
            status    <= long_status;
            err       <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=32). A behavioural model
// tracks expected handshake timing and results; directed cases pin literal
// values, then a randomized phase runs against the model.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [2:0]   status;
  logic         err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .status    (status),
    .err       (err)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [2:0]  st;
    logic        err;
    bit          lng;
  } exp_t;

  // Reference behaviour straight from the opcode definitions.
  function automatic exp_t ref_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    logic        v;
    e.res = '0;
    e.err = 1'b0;
    e.lng = 1'b0;
    v     = 1'b0;
    case (o)
      4'd0: e.res = x & y;
      4'd1: e.res = x | y;
      4'd2: begin
        e.res = x + y;
        v = (x[31] == y[31]) && (e.res[31] != x[31]);
      end
      4'd3: e.res = x ^ y;
      4'd4: e.res = x << y[4:0];
      4'd5: e.res = x >> y[4:0];
      4'd6: begin
        e.res = x - y;
        v = (x[31] != y[31]) && (e.res[31] != x[31]);
      end
      4'd7: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8: begin
        p = {32'd0, x} * {32'd0, y};
        e.res = p[31:0];
        v = (p[63:32] != 0);
        e.lng = 1'b1;
      end
`ifdef ALU_SEQ_DIV_EN
      4'd9: begin
        e.res = (y == 0) ? 32'hFFFF_FFFF : x / y;
        e.lng = 1'b1;
      end
      4'd10: begin
        e.res = (y == 0) ? x : x % y;
        e.lng = 1'b1;
      end
`endif
      default: e.err = 1'b1;
    endcase
    e.st = {e.res[31], v, (e.res == 0)};
    return e;
  endfunction

  // Model state: remaining BUSY cycles, whether a result is presented.
  int   m_busy = 0;
  bit   m_valid = 1'b0;
  bit   m_rdy;
  exp_t m_cur;
  exp_t m_pend;
  exp_t m_new;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 0;
      m_valid = 1'b0;
    end else begin
      m_rdy = (!m_valid && m_busy == 0) || (m_valid && out_ready);
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1'b1;
          m_cur   = m_pend;
        end
      end
      if (in_valid && m_rdy) begin
        m_new = ref_op(op, a, b);
        if (m_new.lng) begin
          m_busy = W;
          m_pend = m_new;
        end else begin
          m_valid = 1'b1;
          m_cur   = m_new;
        end
      end
    end
  end

  bit c_rdy;
  always @(negedge clk) begin
    c_rdy = (!m_valid && m_busy == 0) || (m_valid && out_ready);
    n_checks++;
    if (in_ready !== c_rdy || out_valid !== m_valid ||
        (m_valid && (result !== m_cur.res || status !== m_cur.st || err !== m_cur.err))) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t: in_ready %b/%b out_valid %b/%b result %h/%h status %b/%b err %b/%b",
               $time, in_ready, c_rdy, out_valid, m_valid, result, m_cur.res, status, m_cur.st, err, m_cur.err);
    end
  end

  // Issue one op from IDLE with out_ready=1; call at posedge+1.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] r, output logic [2:0] s,
                        output logic e, output bit rdy_busy);
    bit acc;
    int t;
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
    if (!acc) check("accept_timeout", 0, 1);
    lat = 0;
    rdy_busy = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) rdy_busy = 1'b1;
    end while (!out_valid && lat < 100);
    r = result; s = status; e = err;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int          lat;
  logic [31:0] r;
  logic [2:0]  s;
  logic        e;
  bit          rb;
  bit          seen;
  exp_t        pin;

  initial begin
    // Pin the reference model with hand-computed values.
    pin = ref_op(4'd2, 32'h7FFF_FFFF, 32'd1);
    check("model_add_res", pin.res, 32'h8000_0000);
    check("model_add_st", pin.st, 3'b110);
    pin = ref_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("model_mul_res", pin.res, 32'd1);
    check("model_mul_st", pin.st, 3'b010);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_status", status, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    run_op(4'd2, 32'h7FFF_FFFF, 32'd1, lat, r, s, e, rb);
    check("add_ovf_res", r, 32'h8000_0000);
    check("add_ovf_st", s, 3'b110);
    check("add_lat", lat, 1);

    run_op(4'd6, 32'd5, 32'd5, lat, r, s, e, rb);
    check("sub_res", r, 0);
    check("sub_st", s, 3'b001);

    run_op(4'd7, 32'hFFFF_FFFF, 32'd1, lat, r, s, e, rb);
    check("slt_res", r, 1);

    run_op(4'd8, 32'h0001_0000, 32'h0001_0000, lat, r, s, e, rb);
    check("mul_lat", lat, 33);
    check("mul_res", r, 0);
    check("mul_st", s, 3'b011);
    check("mul_ready_in_busy", rb, 0);

    run_op(4'd15, 32'd3, 32'd4, lat, r, s, e, rb);
    check("illegal_res", r, 0);
    check("illegal_st", s, 3'b001);
    check("illegal_err", e, 1);
    check("illegal_lat", lat, 1);

`ifdef ALU_SEQ_DIV_EN
    run_op(4'd9, 32'd100, 32'd7, lat, r, s, e, rb);
    check("divu_res", r, 14);
    check("divu_lat", lat, 33);
    run_op(4'd10, 32'd100, 32'd7, lat, r, s, e, rb);
    check("remu_res", r, 2);
    run_op(4'd9, 32'd9, 32'd0, lat, r, s, e, rb);
    check("divu0_res", r, 32'hFFFF_FFFF);
    check("divu0_err", e, 0);
`else
    run_op(4'd9, 32'd100, 32'd7, lat, r, s, e, rb);
    check("divu_off_res", r, 0);
    check("divu_off_err", e, 1);
    check("divu_off_lat", lat, 1);
`endif

    // Result held while out_ready is low, then back-to-back acceptance.
    in_valid = 1'b1; op = 4'd2; a = 32'd10; b = 32'd20; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", result, 30);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1; in_valid = 1'b1; op = 4'd2; a = 32'd1; b = 32'd2;
    @(negedge clk);
    check("b2b_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid", out_valid, 1);
    check("b2b_result", result, 3);
    @(posedge clk);
    #1;

    // Reset in the tenth BUSY cycle of a multiply.
    in_valid = 1'b1; op = 4'd8; a = 32'h0001_0000; b = 32'h0001_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_result", result, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", seen, 0);

    // Randomized traffic checked by the model.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      op        = 4'($urandom_range(0, 15));
      a         = rand_operand();
      b         = rand_operand();
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
